// File: rtl/vga_fill_sched.sv
`timescale 1ns/1ps
// Purpose    : framebuffer write-port scheduler sharing one pixel/cycle between a rectangle-fill engine and a single-pixel port.
// Latency    : a grant in cycle N appears on fb_addr_*/fb_color_o/fb_we_o (and done_o/err_o) in cycle N+1; all outputs registered.
// Backpressure: cmd_ready_o only in IDLE; pix_ready_o only when the pixel port wins arbitration (command first in IDLE, round-robin in FILL).
//
// Ports:
//   clk_i, rstn_i                  framebuffer clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o        fill command handshake; cmd_x0/y0/w/h/color_i latched on accept
//   pix_valid_i/pix_ready_o        single-pixel handshake; pix_x/y/color_i used in the grant cycle
//   fb_addr_x_o/fb_addr_y_o        framebuffer write address (holds when nothing is granted)
//   fb_color_o/fb_we_o             framebuffer write colour / strobe (strobe suppressed when out of range)
//   busy_o                         high while a fill is in progress
//   done_o                         one-cycle pulse in the write slot of the last fill pixel (or after an empty command)
//   err_o                          one-cycle pulse when a granted single pixel is out of range and dropped
module vga_fill_sched #(
    parameter int unsigned COORD_W = 11,
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [COORD_W-1:0] cmd_x0_i,
    input  logic [COORD_W-1:0] cmd_y0_i,
    input  logic [COORD_W-1:0] cmd_w_i,
    input  logic [COORD_W-1:0] cmd_h_i,
    input  logic               cmd_color_i,
    input  logic               pix_valid_i,
    output logic               pix_ready_o,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    input  logic               pix_color_i,
    output logic [COORD_W-1:0] fb_addr_x_o,
    output logic [COORD_W-1:0] fb_addr_y_o,
    output logic               fb_color_o,
    output logic               fb_we_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Scan coordinates carry one extra bit so x0+w and y0+h never wrap.
    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);
    localparam logic [COORD_W:0] ONE   = (COORD_W+1)'(1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x0_q, x0_d;
    logic [COORD_W:0]   x_end_q, x_end_d;
    logic [COORD_W:0]   y_end_q, y_end_d;
    logic [COORD_W:0]   cur_x_q, cur_x_d;
    logic [COORD_W:0]   cur_y_q, cur_y_d;
    logic               color_q, color_d;
    // High when the most recent grant in this fill went to the fill engine.
    logic               last_fill_q, last_fill_d;

    logic [COORD_W-1:0] fb_addr_x_q, fb_addr_x_d;
    logic [COORD_W-1:0] fb_addr_y_q, fb_addr_y_d;
    logic               fb_color_q, fb_color_d;
    logic               fb_we_q, fb_we_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               cmd_accept;
    logic               cmd_empty;
    logic               pix_grant;
    logic               fill_grant;
    logic [COORD_W:0]   x_nxt;
    logic [COORD_W:0]   y_nxt;
    logic               x_row_end;
    logic               fill_last;
    logic               fill_in_range;
    logic               pix_in_range;

    // Arbitration and scan bookkeeping
    always_comb begin
        cmd_accept = (state_q == ST_IDLE) && cmd_valid_i;
        cmd_empty  = (cmd_w_i == '0) || (cmd_h_i == '0);

        // A pending command wins in IDLE; in FILL the pixel port only gets
        // a slot directly after a fill slot, so the two alternate under load.
        if (state_q == ST_IDLE) begin
            pix_grant = pix_valid_i && !cmd_valid_i;
        end else begin
            pix_grant = pix_valid_i && last_fill_q;
        end
        fill_grant = (state_q == ST_FILL) && !pix_grant;

        x_nxt     = cur_x_q + ONE;
        y_nxt     = cur_y_q + ONE;
        x_row_end = (x_nxt == x_end_q);
        fill_last = x_row_end && (y_nxt == y_end_q);

        fill_in_range = (cur_x_q < H_LIM) && (cur_y_q < V_LIM);
        pix_in_range  = ({1'b0, pix_x_i} < H_LIM) && ({1'b0, pix_y_i} < V_LIM);
    end

    // Next-state and output-register values
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        x_end_d     = x_end_q;
        y_end_d     = y_end_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        color_d     = color_q;
        last_fill_d = last_fill_q;
        fb_addr_x_d = fb_addr_x_q;
        fb_addr_y_d = fb_addr_y_q;
        fb_color_d  = fb_color_q;
        fb_we_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (cmd_accept) begin
            if (cmd_empty) begin
                // Nothing to draw: acknowledge completion on the next cycle.
                done_d = 1'b1;
            end else begin
                state_d     = ST_FILL;
                x0_d        = cmd_x0_i;
                cur_x_d     = {1'b0, cmd_x0_i};
                cur_y_d     = {1'b0, cmd_y0_i};
                x_end_d     = {1'b0, cmd_x0_i} + {1'b0, cmd_w_i};
                y_end_d     = {1'b0, cmd_y0_i} + {1'b0, cmd_h_i};
                color_d     = cmd_color_i;
                // The first slot of a new fill always goes to the fill engine.
                last_fill_d = 1'b0;
            end
        end else if (pix_grant) begin
            fb_addr_x_d = pix_x_i;
            fb_addr_y_d = pix_y_i;
            fb_color_d  = pix_color_i;
            fb_we_d     = pix_in_range;
            err_d       = !pix_in_range;
            last_fill_d = 1'b0;
        end else if (fill_grant) begin
            // Out-of-range pixels still consume their slot (silent clip).
            fb_addr_x_d = cur_x_q[COORD_W-1:0];
            fb_addr_y_d = cur_y_q[COORD_W-1:0];
            fb_color_d  = color_q;
            fb_we_d     = fill_in_range;
            last_fill_d = 1'b1;
            if (fill_last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else if (x_row_end) begin
                cur_x_d = {1'b0, x0_q};
                cur_y_d = y_nxt;
            end else begin
                cur_x_d = x_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            x0_q        <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            color_q     <= 1'b0;
            last_fill_q <= 1'b0;
            fb_addr_x_q <= '0;
            fb_addr_y_q <= '0;
            fb_color_q  <= 1'b0;
            fb_we_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x_end_q     <= x_end_d;
            y_end_q     <= y_end_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            color_q     <= color_d;
            last_fill_q <= last_fill_d;
            fb_addr_x_q <= fb_addr_x_d;
            fb_addr_y_q <= fb_addr_y_d;
            fb_color_q  <= fb_color_d;
            fb_we_q     <= fb_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign pix_ready_o = pix_grant;
    assign busy_o      = (state_q == ST_FILL);
    assign fb_addr_x_o = fb_addr_x_q;
    assign fb_addr_y_o = fb_addr_y_q;
    assign fb_color_o  = fb_color_q;
    assign fb_we_o     = fb_we_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_vga_fill_sched.sv
`timescale 1ns/1ps
module tb_vga_fill_sched;

    localparam int CW = 11;
    localparam int HR = 640;
    localparam int VR = 480;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [CW-1:0] cmd_x0_i = '0;
    logic [CW-1:0] cmd_y0_i = '0;
    logic [CW-1:0] cmd_w_i = '0;
    logic [CW-1:0] cmd_h_i = '0;
    logic          cmd_color_i = 1'b0;
    logic          pix_valid_i = 1'b0;
    logic          pix_ready_o;
    logic [CW-1:0] pix_x_i = '0;
    logic [CW-1:0] pix_y_i = '0;
    logic          pix_color_i = 1'b0;
    logic [CW-1:0] fb_addr_x_o;
    logic [CW-1:0] fb_addr_y_o;
    logic          fb_color_o;
    logic          fb_we_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    always #5 clk = ~clk;

    vga_fill_sched #(.COORD_W(CW), .H_RES(HR), .V_RES(VR)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_x0_i    (cmd_x0_i),
        .cmd_y0_i    (cmd_y0_i),
        .cmd_w_i     (cmd_w_i),
        .cmd_h_i     (cmd_h_i),
        .cmd_color_i (cmd_color_i),
        .pix_valid_i (pix_valid_i),
        .pix_ready_o (pix_ready_o),
        .pix_x_i     (pix_x_i),
        .pix_y_i     (pix_y_i),
        .pix_color_i (pix_color_i),
        .fb_addr_x_o (fb_addr_x_o),
        .fb_addr_y_o (fb_addr_y_o),
        .fb_color_o  (fb_color_o),
        .fb_we_o     (fb_we_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    // Expected registered outputs for one cycle.
    typedef struct {
        bit we;
        int x;
        int y;
        bit color;
        bit done;
        bit err;
        bit busy;
    } rec_t;

    typedef struct {
        int x;
        int y;
    } pt_t;

    rec_t exp_q[$];
    pt_t  fillq[$];   // pixels of the current rectangle still to be scanned

    bit m_fill      = 1'b0;
    bit m_last_fill = 1'b0;
    bit m_color     = 1'b0;
    int last_x      = 0;
    int last_y      = 0;
    bit last_c      = 1'b0;

    int checks   = 0;
    int failures = 0;
    bit ca, pa;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs after the falling edge, then let the
    // reference model decide what the scheduler must grant and queue the
    // outputs expected after the next rising edge.
    task automatic step(input bit rst_n, input bit cv, input int cx, input int cy,
                        input int cw, input int ch, input bit cc, input bit pv,
                        input int px, input int py, input bit pc,
                        output bit cmd_acc, output bit pix_acc);
        rec_t r;
        bit   gp;
        @(negedge clk);
        rstn_i      = rst_n;
        cmd_valid_i = cv;
        cmd_x0_i    = CW'(cx);
        cmd_y0_i    = CW'(cy);
        cmd_w_i     = CW'(cw);
        cmd_h_i     = CW'(ch);
        cmd_color_i = cc;
        pix_valid_i = pv;
        pix_x_i     = CW'(px);
        pix_y_i     = CW'(py);
        pix_color_i = pc;
        #1;
        cmd_acc = 1'b0;
        pix_acc = 1'b0;
        r.we = 1'b0; r.done = 1'b0; r.err = 1'b0;
        r.x = last_x; r.y = last_y; r.color = last_c;
        if (!rst_n) begin
            m_fill = 1'b0;
            m_last_fill = 1'b0;
            fillq.delete();
            r.x = 0; r.y = 0; r.color = 1'b0;
        end else begin
            check("cmd_ready", cmd_ready_o, !m_fill);
            gp = m_fill ? (pv && m_last_fill) : (pv && !cv);
            check("pix_ready", pix_ready_o, gp);
            if (!m_fill && cv) begin
                cmd_acc = 1'b1;
                if (cw == 0 || ch == 0) begin
                    r.done = 1'b1;
                end else begin
                    for (int yy = cy; yy < cy + ch; yy++)
                        for (int xx = cx; xx < cx + cw; xx++)
                            fillq.push_back('{xx, yy});
                    m_fill = 1'b1;
                    m_last_fill = 1'b0;
                    m_color = cc;
                end
            end else if (gp) begin
                pix_acc = 1'b1;
                r.x = px; r.y = py; r.color = pc;
                r.we = (px < HR) && (py < VR);
                r.err = !r.we;
                m_last_fill = 1'b0;
            end else if (m_fill) begin
                pt_t p;
                p = fillq.pop_front();
                r.x = p.x % 2048;
                r.y = p.y % 2048;
                r.color = m_color;
                r.we = (p.x < HR) && (p.y < VR);
                m_last_fill = 1'b1;
                if (fillq.size() == 0) begin
                    r.done = 1'b1;
                    m_fill = 1'b0;
                end
            end
        end
        r.busy = m_fill;
        last_x = r.x; last_y = r.y; last_c = r.color;
        exp_q.push_back(r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ca, pa);
    endtask

    function automatic int rcoord(input int lim);
        case ($urandom_range(2))
            0:       return int'($urandom_range(lim + 8));
            1:       return int'($urandom_range(lim - 6, lim + 6));
            default: return int'($urandom_range(2040, 2047));
        endcase
    endfunction

    // Monitor: compares what the DUT shows after each rising edge.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("fb_we", fb_we_o, r.we);
                check("fb_addr_x", fb_addr_x_o, r.x);
                check("fb_addr_y", fb_addr_y_o, r.y);
                check("fb_color", fb_color_o, r.color);
                check("done", done_o, r.done);
                check("err", err_o, r.err);
                check("busy", busy_o, r.busy);
                check("cmd_ready_state", cmd_ready_o, !r.busy);
            end
        end
    end

    initial begin
        bit pv, cv, pc, cc;
        int px, py, cx, cy, cw, ch;
        bit rst;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ca, pa);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ca, pa);
        idle(2);

        // 3x2 fill at (10,20)
        step(1, 1, 10, 20, 3, 2, 1, 0, 0, 0, 0, ca, pa);
        idle(8);

        // 4x1 fill contending with a held pixel request
        step(1, 1, 100, 50, 4, 1, 0, 1, 5, 5, 1, ca, pa);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 5, 5, 1, ca, pa);
        idle(2);

        // fill clipped at the bottom-right corner
        step(1, 1, 638, 479, 4, 2, 1, 0, 0, 0, 0, ca, pa);
        idle(10);

        // out-of-range single pixel
        step(1, 0, 0, 0, 0, 0, 0, 1, 700, 10, 1, ca, pa);
        idle(2);

        // empty command
        step(1, 1, 5, 5, 0, 5, 1, 0, 0, 0, 0, ca, pa);
        idle(3);

        // reset in the middle of a 10x10 fill
        step(1, 1, 50, 60, 10, 10, 1, 0, 0, 0, 0, ca, pa);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ca, pa);
        idle(6);

        // randomized traffic; requests are held until accepted
        pv = 0; cv = 0; pc = 0; cc = 0;
        px = 0; py = 0; cx = 0; cy = 0; cw = 0; ch = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pv && $urandom_range(2) == 0) begin
                pv = 1; px = rcoord(HR); py = rcoord(VR); pc = 1'($urandom_range(1));
            end
            if (!cv && $urandom_range(11) == 0) begin
                cv = 1; cx = rcoord(HR); cy = rcoord(VR);
                cw = int'($urandom_range(0, 6)); ch = int'($urandom_range(0, 4));
                cc = 1'($urandom_range(1));
            end
            rst = ($urandom_range(399) != 0);
            step(rst, cv, cx, cy, cw, ch, cc, pv, px, py, pc, ca, pa);
            if (ca || !rst) cv = 0;
            if (pa || !rst) pv = 0;
        end
        idle(40);

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
